max_pool_2x2: RTL and testbench
===============================

// Module: max_pool_2x2
// PURPOSE
//  Downstream of the channel partial-sum/ReLU stage. Captures one H x W map of 8-bit post-ReLU
//  activations on an in_valid pulse and applies 2x2/stride-2 max pooling. Streams pooled values
//  out in raster order, one per out_valid&&out_ready beat, to the next layer's input buffer.
// PARAMETERS
//  DATA_WIDTH  8   activation width; treated as unsigned (post-ReLU)
//  H           12  input map rows
//  W           11  input map columns
//  IDX_WIDTH   4   width of out_row / out_col
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous reset, active low
//  in_valid   in   1                  single-cycle map-valid pulse from partial-sum stage
//  in_data    in   DATA_WIDTH x[H][W] unpacked map, sampled only on acceptance
//  in_ready   out  1                  high in IDLE; map accepted when in_valid && in_ready
//  out_data   out  DATA_WIDTH         pooled value for (out_row,out_col)
//  out_valid  out  1                  pooled beat valid
//  out_ready  in   1                  consumer accepts beat
//  out_row    out  IDX_WIDTH          pooled row index
//  out_col    out  IDX_WIDTH          pooled column index
//  out_last   out  1                  high with the final beat of the map
//  overrun    out  1                  sticky: in_valid seen while busy (map dropped)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_last=0, overrun=0,
//    out_row=out_col=0, out_data=0, capture buffer cleared to 0. Mid-stream reset aborts the map.
//  - FSM: IDLE -> RUN on in_valid (in_data latched in full at that edge).
//    RUN -> IDLE on the handshake of the beat with out_last=1.
//  - Latency: out_valid rises the cycle after acceptance. out_data/out_row/out_col are registered.
//  - out_data = unsigned max of buf[2r][2c], buf[2r][2c+1], buf[2r+1][2c], buf[2r+1][2c+1].
//  - Output grid: PH = H/2 and PW = W/2 (floor). Default: 6x5 = 30 beats.
//  - Odd trailing row or column is discarded.
//  - Stall: while out_valid && !out_ready, all outputs hold stable.
//  - Advance: col increments on each handshake; wraps to 0 at PW-1 and increments row.
//  - out_last = (row==PH-1) && (col==PW-1).
//  - The next map can be accepted no earlier than the cycle after the last handshake (in_ready=1).
//  - in_valid while in_ready=0: input ignored, overrun set to 1 and held until reset.
//  - in_valid in the same cycle as the last handshake: ignored, overrun set.
// CONFIGURATION
//  - Macro MAX_POOL_PAD_EN defined: grid becomes ceil(H/2) x ceil(W/2) (default 6x6 = 36 beats).
//    Window positions outside the map contribute 0 (valid for non-negative data).
//  - Undefined: floor grid; odd edge dropped as above.
// STRUCTURE
//  - Shared package npu_pool_pkg holds:
//    - state encoding (IDLE=0, RUN=1)
//    - localparams POOL_H/POOL_W derived from H, W and MAX_POOL_PAD_EN
//    - DATA_WIDTH default
//  - Sub-module max4_u8: combinational unsigned 4-input max (two-level compare tree).
//    Instantiated once and fed by a window mux indexed by row/col.
//  - Top holds the capture buffer, FSM, index counters, output register and overrun flag.
// TESTING
//  1. Ramp map in_data[i][j]=i*W+j, out_ready=1 -> 30 beats.
//     Beat(0,0)=12, beat(5,4)=130; out_last only on beat 30; in_ready back to 1 the next cycle.
//  2. Backpressure: toggle out_ready 1-0-0-1 -> out_data/row/col stable while stalled.
//     No beat lost or duplicated.
//  3. Odd edge: column 10 = 255, all else 0 -> every beat 0 (column dropped).
//     With MAX_POOL_PAD_EN: 36 beats and col-5 beats = 255.
//  4. Overrun: second in_valid pulse 3 cycles after the first -> overrun=1.
//     Stream still carries first-map values only.
//  5. Reset mid-stream after 7 beats -> out_valid=0 immediately, in_ready=1.
//     A new map streams from (0,0).
//  6. Max ties and extremes: window {255,0,255,1} -> 255; all-zero map -> 30 zero beats.

Source files
------------

// File: rtl/npu_pool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool stage.
// MAX_POOL_PAD_EN selects a ceil-sized pooled grid (zero padding) instead of the floor grid.
package npu_pool_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MAP_H      = 12;
  localparam int MAP_W      = 11;
  localparam int IDX_WIDTH  = 4;

  // Pooled extent along one axis: the odd trailing line is either padded or dropped.
  function automatic int pool_dim(input int n);
`ifdef MAX_POOL_PAD_EN
    return (n + 1) / 2;
`else
    return n / 2;
`endif
  endfunction

  localparam int POOL_H = pool_dim(MAP_H);
  localparam int POOL_W = pool_dim(MAP_W);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_e;

endpackage

// File: rtl/max_pool_2x2_if.sv
// Map-in / pooled-stream-out handshake bundle for max_pool_2x2.
interface max_pool_2x2_if #(
  parameter int DW = npu_pool_pkg::DATA_WIDTH,
  parameter int H  = npu_pool_pkg::MAP_H,
  parameter int W  = npu_pool_pkg::MAP_W,
  parameter int IW = npu_pool_pkg::IDX_WIDTH
);

  logic          in_valid;
  logic [DW-1:0] in_data [H][W];
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;
  logic          overrun;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid, out_row, out_col, out_last, overrun
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid, out_row, out_col, out_last, overrun
  );

endinterface

// File: rtl/max4_u8.sv
// Combinational unsigned maximum of four values, two-level compare tree.
module max4_u8 #(
  parameter int DW = npu_pool_pkg::DATA_WIDTH
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y
);

  logic [DW-1:0] m_ab;
  logic [DW-1:0] m_cd;

  always_comb begin
    m_ab = (a >= b) ? a : b;
    m_cd = (c >= d) ? c : d;
    y    = (m_ab >= m_cd) ? m_ab : m_cd;
  end

endmodule

// File: rtl/max_pool_2x2.sv
// Captures one HxW activation map and streams its 2x2/stride-2 max pool in raster order.
// Build option MAX_POOL_PAD_EN (see npu_pool_pkg) pads odd edges with zeros instead of dropping them.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an in_valid map pulse
// RUN     | map captured, emitting pooled beats until the out_last handshake
module max_pool_2x2 #(
  parameter int DATA_WIDTH = npu_pool_pkg::DATA_WIDTH,
  parameter int H          = npu_pool_pkg::MAP_H,
  parameter int W          = npu_pool_pkg::MAP_W,
  parameter int IDX_WIDTH  = npu_pool_pkg::IDX_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  max_pool_2x2_if.slave  bus
);

  import npu_pool_pkg::*;

  localparam int PH = pool_dim(H);
  localparam int PW = pool_dim(W);
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam logic [IDX_WIDTH:0]   H_L     = (IDX_WIDTH+1)'(H);
  localparam logic [IDX_WIDTH:0]   W_L     = (IDX_WIDTH+1)'(W);
  localparam logic [IDX_WIDTH-1:0] ROW_END = IDX_WIDTH'(PH - 1);
  localparam logic [IDX_WIDTH-1:0] COL_END = IDX_WIDTH'(PW - 1);

  pool_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] cap_q [H][W];
  logic [DATA_WIDTH-1:0] cap_d [H][W];
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_WIDTH-1:0]  row_q, row_d;
  logic [IDX_WIDTH-1:0]  col_q, col_d;

  logic                  accept;
  logic                  beat_done;
  logic [IDX_WIDTH-1:0]  row_nxt, col_nxt;
  logic [IDX_WIDTH-1:0]  row_sel, col_sel;
  logic [IDX_WIDTH:0]    r0, r1, c0, c1;
  logic [DATA_WIDTH-1:0] win [4];
  logic [DATA_WIDTH-1:0] max_val;

  // In IDLE the first window comes straight from in_data so beat (0,0) is ready the
  // cycle after acceptance; afterwards the captured copy is used.
  function automatic logic [DATA_WIDTH-1:0] px(input logic [IDX_WIDTH:0] rr,
                                               input logic [IDX_WIDTH:0] cc);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if ((rr < H_L) && (cc < W_L)) begin
      if (state_q == ST_IDLE) v = bus.in_data[rr[RW-1:0]][cc[CW-1:0]];
      else                    v = cap_q[rr[RW-1:0]][cc[CW-1:0]];
    end
    return v;
  endfunction

  assign accept    = bus.in_valid && in_ready_q;
  assign beat_done = out_valid_q && bus.out_ready;

  always_comb begin
    col_nxt = col_q + 1'b1;
    row_nxt = row_q;
    if (col_q == COL_END) begin
      col_nxt = '0;
      row_nxt = row_q + 1'b1;
    end
    row_sel = (state_q == ST_IDLE) ? '0 : row_nxt;
    col_sel = (state_q == ST_IDLE) ? '0 : col_nxt;
    r0      = {row_sel, 1'b0};
    r1      = {row_sel, 1'b1};
    c0      = {col_sel, 1'b0};
    c1      = {col_sel, 1'b1};
    win[0]  = px(r0, c0);
    win[1]  = px(r0, c1);
    win[2]  = px(r1, c0);
    win[3]  = px(r1, c1);
  end

  max4_u8 #(.DW(DATA_WIDTH)) u_max4 (
    .a (win[0]),
    .b (win[1]),
    .c (win[2]),
    .d (win[3]),
    .y (max_val)
  );

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    row_d       = row_q;
    col_d       = col_q;
    overrun_d   = overrun_q | (bus.in_valid & ~in_ready_q);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_RUN;
          cap_d       = bus.in_data;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = max_val;
          row_d       = '0;
          col_d       = '0;
          out_last_d  = (ROW_END == '0) && (COL_END == '0);
        end
      end
      ST_RUN: begin
        if (beat_done) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            row_d       = '0;
            col_d       = '0;
          end else begin
            row_d      = row_nxt;
            col_d      = col_nxt;
            out_data_d = max_val;
            out_last_d = (row_nxt == ROW_END) && (col_nxt == COL_END);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cap_q       <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      out_data_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
      out_data_q  <= out_data_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed self-checking bench for max_pool_2x2 (default build or MAX_POOL_PAD_EN).
module tb_max_pool_2x2;

  localparam int DW = 8;
  localparam int H  = 12;
  localparam int W  = 11;
  localparam int IW = 4;
`ifdef MAX_POOL_PAD_EN
  localparam int PH = 6;
  localparam int PW = 6;
  localparam int RAMP_LAST = 131;
  localparam int EDGE_LAST = 255;
`else
  localparam int PH = 6;
  localparam int PW = 5;
  localparam int RAMP_LAST = 130;
  localparam int EDGE_LAST = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  max_pool_2x2_if #(.DW(DW), .H(H), .W(W), .IW(IW)) bus ();

  max_pool_2x2 #(.DATA_WIDTH(DW), .H(H), .W(W), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int ntests = 0;
  int nfail  = 0;
  logic [DW-1:0] map_ref [H][W];
  logic [DW-1:0] map_tmp [H][W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int px_ref(input int i, input int j);
    if (i < H && j < W) return int'(map_ref[i][j]);
    return 0;
  endfunction

  function automatic int pool_ref(input int r, input int c);
    int m;
    m = px_ref(2*r, 2*c);
    if (px_ref(2*r, 2*c+1) > m)   m = px_ref(2*r, 2*c+1);
    if (px_ref(2*r+1, 2*c) > m)   m = px_ref(2*r+1, 2*c);
    if (px_ref(2*r+1, 2*c+1) > m) m = px_ref(2*r+1, 2*c+1);
    return m;
  endfunction

  // Pulse in_valid with map_tmp; returns on the negedge after the accepting edge.
  task automatic send_map();
    map_ref = map_tmp;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = map_tmp;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called on a negedge; mode 1 drives out_ready with the repeating pattern 1,0,0,1.
  task automatic stream(input int mode, input int nbeats, output int beats,
                        output int first_v, output int last_v);
    int r, c, cyc;
    logic stalled;
    logic [DW-1:0] hd;
    logic [IW-1:0] hr, hc;
    r = 0; c = 0; cyc = 0; stalled = 1'b0; beats = 0; first_v = -1; last_v = -1;
    hd = '0; hr = '0; hc = '0;
    while (beats < nbeats && cyc < 3000) begin
      if (stalled) begin
        chk("stall_data", bus.out_data, hd);
        chk("stall_row", bus.out_row, hr);
        chk("stall_col", bus.out_col, hc);
      end
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      stalled = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          chk($sformatf("data_%0d_%0d", r, c), bus.out_data, pool_ref(r, c));
          chk("beat_row", bus.out_row, r);
          chk("beat_col", bus.out_col, c);
          chk("beat_last", bus.out_last, (r == PH-1) && (c == PW-1));
          if (beats == 0) first_v = int'(bus.out_data);
          last_v = int'(bus.out_data);
          beats++;
          c++;
          if (c == PW) begin c = 0; r++; end
        end else begin
          stalled = 1'b1;
          hd = bus.out_data; hr = bus.out_row; hc = bus.out_col;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (beats < nbeats) chk("stream_timeout_beats", beats, nbeats);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    int beats, fv, lv;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = '0;
    bus.in_data = map_tmp;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_col", bus.out_col, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ramp map, free-flowing consumer
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = 8'(i*W + j);
    send_map();
    chk("ramp_latency_valid", bus.out_valid, 1'b1);
    chk("ramp_busy_in_ready", bus.in_ready, 1'b0);
    stream(0, PH*PW, beats, fv, lv);
    chk("ramp_beats", beats, PH*PW);
    chk("ramp_first", fv, 12);
    chk("ramp_last", lv, RAMP_LAST);
    end_checks("ramp_done");

    // backpressure with a scrambled map
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = 8'((i*37 + j*91 + 5) % 256);
    send_map();
    stream(1, PH*PW, beats, fv, lv);
    chk("bp_beats", beats, PH*PW);
    end_checks("bp_done");

    // odd trailing column holds 255, everything else 0
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = (j == W-1) ? 8'd255 : 8'd0;
    send_map();
    stream(0, PH*PW, beats, fv, lv);
    chk("edge_beats", beats, PH*PW);
    chk("edge_last", lv, EDGE_LAST);
    end_checks("edge_done");

    // overrun: second pulse three cycles after acceptance is dropped
    chk("pre_overrun", bus.overrun, 1'b0);
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = 8'((i + 3*j) % 256);
    send_map();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = 8'd200;
    bus.in_valid = 1'b1;
    bus.in_data  = map_tmp;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("overrun_set", bus.overrun, 1'b1);
    stream(0, PH*PW, beats, fv, lv);
    chk("overrun_first", fv, 4);
    chk("overrun_sticky", bus.overrun, 1'b1);
    end_checks("overrun_done");

    // reset after seven beats aborts the map
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = 8'(255 - (i*W + j));
    send_map();
    stream(0, 7, beats, fv, lv);
    chk("mid_valid_before_rst", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_overrun", bus.overrun, 1'b0);
    chk("mid_rst_row", bus.out_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = 8'((i*j) % 256);
    send_map();
    stream(0, PH*PW, beats, fv, lv);
    chk("restart_beats", beats, PH*PW);
    end_checks("restart_done");

    // ties and extremes in individual windows
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = '0;
    map_tmp[0][0] = 8'd255; map_tmp[0][1] = 8'd0;
    map_tmp[1][0] = 8'd255; map_tmp[1][1] = 8'd1;
    map_tmp[5][7] = 8'd1;
    send_map();
    stream(0, PH*PW, beats, fv, lv);
    chk("tie_first", fv, 255);
    end_checks("tie_done");

    // all-zero map
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) map_tmp[i][j] = '0;
    send_map();
    stream(0, PH*PW, beats, fv, lv);
    chk("zero_beats", beats, PH*PW);
    chk("zero_last", lv, 0);
    end_checks("zero_done");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
